// File: rtl/mining_ctrl_pkg.sv
// mining_ctrl_pkg -- shared definitions for the nonce-search controller.
//   * state_t      : controller state encoding (IDLE, ISSUE, WAIT, CHECK, DRAIN)
//   * *_W          : header / block / hash / nonce widths
//   * byte_rev32   : byte-order reversal of a 32-bit word
//   * byte_rev256  : byte-order reversal of a 256-bit hash
package mining_ctrl_pkg;

   localparam int HEADER_W = 608;
   localparam int BLOCK_W  = 640;
   localparam int HASH_W   = 256;
   localparam int NONCE_W  = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DRAIN = 3'd4
   } state_t;

   function automatic logic [31:0] byte_rev32(input logic [31:0] x);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = x[8*(3-i) +: 8];
      end
      return r;
   endfunction

   function automatic logic [255:0] byte_rev256(input logic [255:0] x);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[8*i +: 8] = x[8*(31-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mining_ctrl.sv
// mining_ctrl -- drives an external sha256 core across an inclusive nonce
// range and stops on the first hash (little-endian view) <= target.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   start, abort             : begin a search (IDLE only) / stop the search
//   header, nonce_start,
//   nonce_end, target        : search job, latched on an accepted start
//   sha_start, sha_block     : request pulse and 640-bit block to the core
//   sha_hash, sha_done       : result and level done from the core
//   busy, found, exhausted,
//   timeout_err              : status (found/exhausted/timeout_err sticky)
//   nonce_out, hash_out      : winning / last nonce, byte-reversed hash
//   hash_cnt                 : only with MINER_STATS_EN defined -- number of
//                              hashes checked since the last start, saturating
//
// Parameter TIMEOUT_CYCLES: WAIT cycles allowed per nonce before timeout_err.
module mining_ctrl
   import mining_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4095
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [HEADER_W-1:0] header,
   input  logic [NONCE_W-1:0]  nonce_start,
   input  logic [NONCE_W-1:0]  nonce_end,
   input  logic [HASH_W-1:0]   target,
   output logic                sha_start,
   output logic [BLOCK_W-1:0]  sha_block,
   input  logic [HASH_W-1:0]   sha_hash,
   input  logic                sha_done,
   output logic                busy,
   output logic                found,
   output logic                exhausted,
   output logic                timeout_err,
`ifdef MINER_STATS_EN
   output logic [31:0]         hash_cnt,
`endif
   output logic [NONCE_W-1:0]  nonce_out,
   output logic [HASH_W-1:0]   hash_out
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t              state_reg, state_next;
   logic [HEADER_W-1:0] header_reg;
   logic [NONCE_W-1:0]  nonce_reg;
   logic [NONCE_W-1:0]  nonce_end_reg;
   logic [HASH_W-1:0]   target_reg;
   logic [CNT_W-1:0]    wait_cnt_reg;

   logic [HASH_W-1:0]   hash_le;
   logic                hit;
   logic                done_seen;
   logic                timed_out;
   logic                range_empty;

   assign hash_le     = byte_rev256(sha_hash);
   assign hit         = (hash_le <= target_reg);
   // The first WAIT cycle (count 0) may still see done from the previous nonce.
   assign done_seen   = sha_done && (wait_cnt_reg != '0);
   assign timed_out   = (wait_cnt_reg >= CNT_LAST);
   assign range_empty = (nonce_end < nonce_start);

   // Only nonce_reg changes while a request is outstanding, and only in CHECK,
   // so the block stays stable from ISSUE until the core reports done.
   assign sha_block = {header_reg, byte_rev32(nonce_reg)};
   assign busy      = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sha_start  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !range_empty) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            sha_start  = 1'b1;
            state_next = abort ? IDLE : WAIT;
         end
         WAIT: begin
            if (abort) begin
               state_next = DRAIN;
            end else if (done_seen) begin
               state_next = CHECK;
            end else if (timed_out) begin
               state_next = IDLE;
            end
         end
         CHECK: begin
            // A hit outranks abort; the end-of-range test comes before any
            // increment so a range ending at all-ones never wraps.
            if (hit || abort || (nonce_reg == nonce_end_reg)) begin
               state_next = IDLE;
            end else begin
               state_next = ISSUE;
            end
         end
         DRAIN: begin
            // Let the core finish the abandoned request before going idle.
            if (done_seen || timed_out) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         header_reg    <= '0;
         nonce_reg     <= '0;
         nonce_end_reg <= '0;
         target_reg    <= '0;
         wait_cnt_reg  <= '0;
         found         <= 1'b0;
         exhausted     <= 1'b0;
         timeout_err   <= 1'b0;
         nonce_out     <= '0;
         hash_out      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  header_reg    <= header;
                  nonce_reg     <= nonce_start;
                  nonce_end_reg <= nonce_end;
                  target_reg    <= target;
                  found         <= 1'b0;
                  exhausted     <= range_empty;
                  timeout_err   <= 1'b0;
               end
            end
            ISSUE: begin
               wait_cnt_reg <= '0;
            end
            WAIT: begin
               wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
               if (state_next == IDLE) begin
                  timeout_err <= 1'b1;
               end
            end
            DRAIN: begin
               wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            end
            CHECK: begin
               if (hit) begin
                  found     <= 1'b1;
                  nonce_out <= nonce_reg;
                  hash_out  <= hash_le;
               end else if (state_next == ISSUE) begin
                  nonce_reg <= nonce_reg + NONCE_W'(1);
               end else if (!abort) begin
                  exhausted <= 1'b1;
                  nonce_out <= nonce_reg;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MINER_STATS_EN
   logic [31:0] hash_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         hash_cnt_reg <= '0;
      end else if ((state_reg == IDLE) && start) begin
         hash_cnt_reg <= '0;
      end else if ((state_reg == WAIT) && (state_next == CHECK) && (hash_cnt_reg != '1)) begin
         hash_cnt_reg <= hash_cnt_reg + 32'd1;
      end
   end

   assign hash_cnt = hash_cnt_reg;
`endif

endmodule

// File: doc/mining_ctrl.md
MINING_CTRL -- requirements
Module: mining_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4095: maximum cycles to wait for sha_done per nonce before declaring an error.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  request to stop the current search.
REQ-006 SHALL have port header  input  608  first 76 header bytes, MSB-first, without the nonce.
REQ-007 SHALL have ports nonce_start and nonce_end  input  32 each  inclusive nonce range.
REQ-008 SHALL have port target  input  256  unsigned difficulty target.
REQ-009 SHALL have port sha_start  output  1  one-cycle start pulse to the sha256 core.
REQ-010 SHALL have port sha_block  output  640  {header, byte-reversed nonce}, held stable from the sha_start cycle until sha_done.
REQ-011 SHALL have ports sha_hash  input  256  and sha_done  input  1  (level) from the sha256 core.
REQ-012 SHALL have status outputs busy, found, exhausted, timeout_err  output  1 each.
REQ-013 SHALL have outputs nonce_out  output  32  (winning nonce, or last nonce tried) and hash_out  output  256  (byte-reversed hash of the winning nonce).

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, CHECK, DRAIN.
REQ-015 IDLE: start=1 latches header, nonce_start, nonce_end and target, clears found/exhausted/timeout_err, and moves to ISSUE; if nonce_end < nonce_start it instead sets exhausted and stays in IDLE with no sha_start issued.
REQ-016 ISSUE: asserts sha_start for exactly one cycle with sha_block = {header, nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]}, then enters WAIT.
REQ-017 WAIT: ignores sha_done in the first WAIT cycle (stale done); afterwards sha_done=1 enters CHECK.
REQ-018 WAIT: a per-nonce counter reaching TIMEOUT_CYCLES without sha_done sets timeout_err and returns to IDLE.
REQ-019 CHECK: hash_le = byte-reverse(sha_hash); hit when hash_le <= target (unsigned 256-bit).
REQ-020 CHECK, on a hit: sets found, nonce_out = nonce and hash_out = hash_le, then returns to IDLE.
REQ-021 CHECK, on a miss with nonce == nonce_end: sets exhausted, nonce_out = nonce, then returns to IDLE.
REQ-022 CHECK, on any other miss: increments nonce and returns to ISSUE.
REQ-023 The end-of-range compare SHALL precede the increment so that nonce_end = 0xFFFFFFFF terminates without wrap.
REQ-024 abort in ISSUE or CHECK returns to IDLE next cycle; abort in WAIT enters DRAIN, which waits for sha_done (or timeout) and then goes to IDLE; found and exhausted stay 0.
REQ-025 If abort and a hit occur in the same CHECK cycle, the hit wins.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 busy = 1 in every state except IDLE.
REQ-028 found, exhausted and timeout_err are sticky until the next accepted start or reset.
REQ-029 Per-nonce overhead SHALL be 3 cycles plus the core latency.

Reset
REQ-030 rst=1 at a clock edge forces IDLE and clears sha_start, busy, found, exhausted, timeout_err, nonce_out, hash_out, all latched inputs and the counters.
REQ-031 Reset mid-search abandons the search with no further sha_start issued.

Configuration
REQ-032 With MINER_STATS_EN defined, SHALL add output hash_cnt[31:0]: cleared on an accepted start, incremented once per CHECK entry, and saturating at 0xFFFFFFFF.
REQ-033 Without MINER_STATS_EN, SHALL have no hash_cnt port and no counter logic.

Structure
REQ-034 A shared package SHALL hold the state enum, HEADER_W=608, BLOCK_W=640, HASH_W=256, NONCE_W=32, and a byte-reverse function for 32 and 256 bits.
REQ-035 The sha256 core SHALL be instantiated outside this block by its parent; mining_ctrl has no sub-modules.

Verification
REQ-036 Genesis header, nonce range 0x7C2BAC18..0x7C2BAC20, target 0x00000000FFFF0000...0, real sha256 core -> found=1, nonce_out=0x7C2BAC1D, hash_out=0x000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f, 6 sha_start pulses.
REQ-037 Same header, range 0x00000000..0x00000003, target 0 -> exhausted=1, nonce_out=3, exactly 4 sha_start pulses.
REQ-038 nonce_start=5, nonce_end=4 -> exhausted=1 one cycle after start, no sha_start, busy never 1.
REQ-039 Stub core that always misses, range 0xFFFFFFFE..0xFFFFFFFF -> 2 pulses, exhausted=1, nonce_out=0xFFFFFFFF, no wrap to 0.
REQ-040 Stub core never asserting done, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT cycles, busy=0.
REQ-041 Abort during WAIT -> DRAIN until sha_done, then IDLE; found=0, exhausted=0; a new start is accepted afterwards.
